// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int REQ_ADDRESS_WIDTH = 32;
    localparam int REQ_WORD_WIDTH    = 32;

    // One request beat as seen by a requester (default 32-bit build).
    typedef struct packed {
        logic                         write;
        logic [REQ_ADDRESS_WIDTH-1:0] address;
        logic [REQ_WORD_WIDTH-1:0]    wdata;
    } req_t;

    // Ownership state that corresponds to a granted port.
    function automatic arb_state_t own_state(input logic port);
        return (port == PORT1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/memory_arbiter_pick.sv
// Tie-break between the two ports when the arbiter is idle.
// MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin on ties (port not granted
// most recently wins); otherwise port 0 has fixed priority.
module arbiter_pick
    import memory_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic winner
);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // Tie goes to the port opposite the most recent grant.
    always_comb begin
        winner = PORT0;
        if (valid0 && valid1) begin
            winner = ~last;
        end else if (valid1) begin
            winner = PORT1;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is absent.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        winner = PORT0;
        if (!valid0 && valid1) begin
            winner = PORT1;
        end
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Optional feature macro: MEMORY_ARBITER_ROUND_ROBIN_EN (round-robin idle ties).
//
// Handshake: a beat transfers on a cycle where reqN_valid and reqN_ready are
// both high. ready is combinational from valid and arbiter state, valid must
// not depend on ready, and a requester keeps valid and its fields stable until
// ready. Loads answer with a one-cycle respN_valid pulse after the accepting
// edge; stores produce no response.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int address_width = 32,
    parameter int word_width    = 32,
    parameter int max_burst     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_write,
    input  logic [address_width-1:0] req0_address,
    input  logic [word_width-1:0]    req0_wdata,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_write,
    input  logic [address_width-1:0] req1_address,
    input  logic [word_width-1:0]    req1_wdata,
    output logic                     resp0_valid,
    output logic [word_width-1:0]    resp0_rdata,
    output logic                     resp1_valid,
    output logic [word_width-1:0]    resp1_rdata,
    output logic                     mem_write_enable,
    output logic [address_width-1:0] mem_address,
    output logic [word_width-1:0]    mem_write_data,
    input  logic [word_width-1:0]    mem_read_data,
    output logic [1:0]               debug_state
);

    localparam int beat_width = $clog2(max_burst + 1);
    localparam logic [beat_width-1:0] beats_max = beat_width'(max_burst);
    localparam logic [beat_width-1:0] beats_one = beat_width'(1);

    arb_state_t            state, state_next;
    logic [beat_width-1:0] beats, beats_next;
    logic                  grant;
    logic                  grant_port;
    logic                  owner_port;
    logic                  owner_valid;
    logic                  other_valid;
    logic                  last;
    logic                  pick_winner;
    logic                  resp0_pending;
    logic                  resp1_pending;

    arbiter_pick u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last   (last),
        .winner (pick_winner)
    );

    // Next state, beat count and grant; nothing is granted while reset is high.
    always_comb begin
        state_next  = state;
        beats_next  = beats;
        grant       = 1'b0;
        grant_port  = PORT0;
        owner_port  = (state == OWN1) ? PORT1 : PORT0;
        owner_valid = (owner_port == PORT1) ? req1_valid : req0_valid;
        other_valid = (owner_port == PORT1) ? req0_valid : req1_valid;
        if (!reset) begin
            if (state == IDLE) begin
                if (req0_valid || req1_valid) begin
                    grant      = 1'b1;
                    grant_port = pick_winner;
                    state_next = own_state(pick_winner);
                    beats_next = beats_one;
                end
            end else if (owner_valid && (beats < beats_max)) begin
                grant      = 1'b1;
                grant_port = owner_port;
                beats_next = beats + beats_one;
            end else if (other_valid) begin
                // Burst exhausted or owner gone: hand over with no dead cycle.
                grant      = 1'b1;
                grant_port = ~owner_port;
                state_next = own_state(~owner_port);
                beats_next = beats_one;
            end else if (owner_valid) begin
                // Nobody waiting, so the owner simply starts a fresh burst.
                grant      = 1'b1;
                grant_port = owner_port;
                beats_next = beats_one;
            end else begin
                state_next = IDLE;
                beats_next = '0;
            end
        end
    end

    // State and beat counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            beats <= '0;
        end else begin
            state <= state_next;
            beats <= beats_next;
        end
    end

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // Remember the most recently granted port for idle tie-breaks.
    always_ff @(posedge clock) begin
        if (reset) begin
            last <= PORT1;
        end else if (grant) begin
            last <= grant_port;
        end
    end
`else
    assign last = PORT1;
`endif

    assign req0_ready       = grant && (grant_port == PORT0);
    assign req1_ready       = grant && (grant_port == PORT1);
    assign mem_address      = (grant_port == PORT1) ? req1_address : req0_address;
    assign mem_write_data   = (grant_port == PORT1) ? req1_wdata : req0_wdata;
    assign mem_write_enable = grant && ((grant_port == PORT1) ? req1_write : req0_write);
    assign debug_state      = state;

    // Capture load data on the accepting edge for a one-cycle response.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp0_pending <= 1'b0;
            resp1_pending <= 1'b0;
            resp0_rdata   <= '0;
            resp1_rdata   <= '0;
        end else begin
            resp0_pending <= req0_ready && !req0_write;
            resp1_pending <= req1_ready && !req1_write;
            if (req0_ready && !req0_write) begin
                resp0_rdata <= mem_read_data;
            end
            if (req1_ready && !req1_write) begin
                resp1_rdata <= mem_read_data;
            end
        end
    end

    // A response due during a reset cycle is dropped.
    assign resp0_valid = resp0_pending && !reset;
    assign resp1_valid = resp1_pending && !reset;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural data memory.
// Optional feature macro: MEMORY_ARBITER_ROUND_ROBIN_EN (adds tie alternation test).
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        req0_valid, req0_ready, req0_write;
    logic [31:0] req0_address, req0_wdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [31:0] req1_address, req1_wdata;
    logic        resp0_valid, resp1_valid;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        mem_write_enable;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [1:0]  debug_state;

    logic [31:0] mem [0:255];
    logic [1:0]  exp_q[$];

    int checks;
    int errors;

    memory_arbiter #(
        .address_width (32),
        .word_width    (32),
        .max_burst     (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_write       (req0_write),
        .req0_address     (req0_address),
        .req0_wdata       (req0_wdata),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_write       (req1_write),
        .req1_address     (req1_address),
        .req1_wdata       (req1_wdata),
        .resp0_valid      (resp0_valid),
        .resp0_rdata      (resp0_rdata),
        .resp1_valid      (resp1_valid),
        .resp1_rdata      (resp1_rdata),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .debug_state      (debug_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory model: async read, posedge write, word addressed.
    assign mem_read_data = mem[mem_address[9:2]];
    always @(posedge clock) begin
        if (mem_write_enable) mem[mem_address[9:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic port, input logic valid, input req_t r);
        if (port == PORT0) begin
            req0_valid = valid; req0_write = r.write; req0_address = r.address; req0_wdata = r.wdata;
        end else begin
            req1_valid = valid; req1_write = r.write; req1_address = r.address; req1_wdata = r.wdata;
        end
    endtask

    function automatic req_t mk(input logic write, input logic [31:0] address, input logic [31:0] wdata);
        req_t r;
        r.write = write; r.address = address; r.wdata = wdata;
        return r;
    endfunction

    // Compare the cycle's grant against the head of the expected queue.
    task automatic check_grant(input string tag);
        logic [1:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {62'd0, req1_ready, req0_ready}, {62'd0, exp});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

        // Reset: nothing granted even with both ports requesting stores.
        reset = 1'b1;
        drive(PORT0, 1'b1, mk(1'b1, 32'h10, 32'h1111_1111));
        drive(PORT1, 1'b1, mk(1'b1, 32'h14, 32'h2222_2222));
        @(negedge clock);
        check("rst_ready0", {63'd0, req0_ready}, 64'd0);
        check("rst_ready1", {63'd0, req1_ready}, 64'd0);
        check("rst_we", {63'd0, mem_write_enable}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        drive(PORT0, 1'b0, mk(1'b0, 32'h0, 32'h0));
        drive(PORT1, 1'b0, mk(1'b0, 32'h0, 32'h0));
        @(negedge clock);
        check("rst_state", {62'd0, debug_state}, {62'd0, IDLE});
        check("rst_resp0_valid", {63'd0, resp0_valid}, 64'd0);
        check("rst_resp1_valid", {63'd0, resp1_valid}, 64'd0);
        check("rst_resp0_rdata", {32'd0, resp0_rdata}, 64'd0);
        check("rst_resp1_rdata", {32'd0, resp1_rdata}, 64'd0);

        // Port 0 store then load of the same address.
        tick();
        drive(PORT0, 1'b1, mk(1'b1, 32'h10, 32'hDEAD_BEEF));
        @(negedge clock);
        check("st0_ready0", {63'd0, req0_ready}, 64'd1);
        check("st0_ready1", {63'd0, req1_ready}, 64'd0);
        check("st0_we", {63'd0, mem_write_enable}, 64'd1);
        check("st0_addr", {32'd0, mem_address}, 64'h10);
        check("st0_wdata", {32'd0, mem_write_data}, 64'hDEAD_BEEF);
        tick();
        drive(PORT0, 1'b1, mk(1'b0, 32'h10, 32'h0));
        @(negedge clock);
        check("ld0_ready0", {63'd0, req0_ready}, 64'd1);
        check("ld0_we", {63'd0, mem_write_enable}, 64'd0);
        tick();
        drive(PORT0, 1'b0, mk(1'b0, 32'h0, 32'h0));
        @(negedge clock);
        check("ld0_resp_valid", {63'd0, resp0_valid}, 64'd1);
        check("ld0_resp_rdata", {32'd0, resp0_rdata}, 64'hDEAD_BEEF);
        check("ld0_resp1_quiet", {63'd0, resp1_valid}, 64'd0);
        tick();
        @(negedge clock);
        check("ld0_pulse_end", {63'd0, resp0_valid}, 64'd0);
        check("ld0_rdata_hold", {32'd0, resp0_rdata}, 64'hDEAD_BEEF);
        check("ld0_back_idle", {62'd0, debug_state}, {62'd0, IDLE});

        // Port 1 store at n, port 0 load of the same address at n+1.
        tick();
        drive(PORT1, 1'b1, mk(1'b1, 32'h20, 32'h5));
        @(negedge clock);
        check("x_st1_ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        drive(PORT1, 1'b0, mk(1'b0, 32'h0, 32'h0));
        drive(PORT0, 1'b1, mk(1'b0, 32'h20, 32'h0));
        @(negedge clock);
        check("x_ld0_ready0", {63'd0, req0_ready}, 64'd1);
        check("x_ld0_ready1", {63'd0, req1_ready}, 64'd0);
        check("x_st1_no_resp", {63'd0, resp1_valid}, 64'd0);
        tick();
        drive(PORT0, 1'b0, mk(1'b0, 32'h0, 32'h0));
        @(negedge clock);
        check("x_resp0_valid", {63'd0, resp0_valid}, 64'd1);
        check("x_resp0_rdata", {32'd0, resp0_rdata}, 64'h5);

        // Both ports loading continuously from a fresh reset: 4/4 bursts.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(PORT0, 1'b1, mk(1'b0, 32'h40, 32'h0));
        drive(PORT1, 1'b1, mk(1'b0, 32'h44, 32'h0));
        for (int i = 0; i < 4; i++) exp_q.push_back(2'b01);
        for (int i = 0; i < 4; i++) exp_q.push_back(2'b10);
        for (int i = 0; i < 2; i++) exp_q.push_back(2'b01);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_grant($sformatf("burst_grant_%0d", i));
            tick();
        end
        drive(PORT0, 1'b0, mk(1'b0, 32'h0, 32'h0));
        drive(PORT1, 1'b0, mk(1'b0, 32'h0, 32'h0));
        @(negedge clock);
        check("burst_resp0_valid", {63'd0, resp0_valid}, 64'd1);
        check("burst_resp0_rdata", {32'd0, resp0_rdata}, 64'hA000_0010);
        check("burst_resp1_rdata", {32'd0, resp1_rdata}, 64'hA000_0011);

        // Port 1 alone for 10 cycles: never stalls across burst limits.
        tick();
        tick();
        drive(PORT1, 1'b1, mk(1'b0, 32'h48, 32'h0));
        for (int i = 0; i < 10; i++) exp_q.push_back(2'b10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_grant($sformatf("solo1_grant_%0d", i));
            tick();
        end
        drive(PORT1, 1'b0, mk(1'b0, 32'h0, 32'h0));
        @(negedge clock);
        check("solo1_resp_valid", {63'd0, resp1_valid}, 64'd1);
        check("solo1_resp_rdata", {32'd0, resp1_rdata}, 64'hA000_0012);

        // Reset the cycle after a port 0 load is accepted.
        tick();
        drive(PORT0, 1'b1, mk(1'b0, 32'h10, 32'h0));
        @(negedge clock);
        check("mid_ld_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        reset = 1'b1;
        drive(PORT0, 1'b1, mk(1'b1, 32'h10, 32'h0));
        drive(PORT1, 1'b1, mk(1'b1, 32'h14, 32'h0));
        @(negedge clock);
        check("mid_resp0_suppressed", {63'd0, resp0_valid}, 64'd0);
        check("mid_ready0", {63'd0, req0_ready}, 64'd0);
        check("mid_ready1", {63'd0, req1_ready}, 64'd0);
        check("mid_we", {63'd0, mem_write_enable}, 64'd0);
        tick();
        reset = 1'b0;
        drive(PORT0, 1'b0, mk(1'b0, 32'h0, 32'h0));
        drive(PORT1, 1'b0, mk(1'b0, 32'h0, 32'h0));
        @(negedge clock);
        check("mid_state_idle", {62'd0, debug_state}, {62'd0, IDLE});
        check("mid_resp0_valid", {63'd0, resp0_valid}, 64'd0);
        check("mid_resp0_rdata", {32'd0, resp0_rdata}, 64'd0);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        // Single-beat ties from IDLE alternate 0,1,0,1 after reset.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        for (int i = 0; i < 4; i++) begin
            drive(PORT0, 1'b1, mk(1'b0, 32'h50, 32'h0));
            drive(PORT1, 1'b1, mk(1'b0, 32'h54, 32'h0));
            @(negedge clock);
            check_grant($sformatf("rr_tie_%0d", i));
            tick();
            drive(PORT0, 1'b0, mk(1'b0, 32'h0, 32'h0));
            drive(PORT1, 1'b0, mk(1'b0, 32'h0, 32'h0));
            tick();
        end
`endif

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
